lfsr_8b_gen: RTL and testbench
==============================

Name: lfsr_8b_gen

Overview:
- Free-running 8-bit maximal-length Fibonacci LFSR, used as a pseudo-random pattern source (memory-controller BIST/BISR data and address scrambling).
- Advances one state per clock once reset is released.
- The current state drives the output directly; there is no output logic.

Parameters:
- SEED, 8'h01, state loaded on reset. A value of 8'h00 is illegal; the block substitutes 8'h01.
- TAPS, 8'hB8, feedback tap mask over state bits 7..0. Default taps are bits 7, 5, 4, 3, giving x^8+x^6+x^5+x^4+1 with period 255.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rstn  input  1  reset, asynchronous and active-high. The port keeps the codebase name `rstn`, but it is asserted at logic 1.
- out  output  8  current LFSR state, registered.

Behaviour:
- Reset
  - While rstn=1, state is forced to SEED (8'h00 mapped to 8'h01) immediately, with no clock needed.
  - out = SEED throughout reset.
  - Asserting reset mid-sequence aborts the sequence at once, regardless of clk.
- Release
  - On rstn 1->0 the state holds SEED until the first rising clk edge.
  - That edge produces the first new value. Latency: 1 cycle per step.
- Step, on each rising clk edge with rstn=0:
  - fb = XOR-reduce(state & TAPS).
  - next = {state[6:0], fb}: shift left, feedback enters bit 0.
- Sequence from 8'h01 with default TAPS: 01, 02, 04, 08, 11, 23, 47, 8E, 1C, 38, ...
- Period and zero state:
  - Period is exactly 255. The sequence repeats SEED on the 255th step.
  - 8'h00 never appears.
- Lock-up guard: if the state is ever 8'h00 (e.g., SEU or illegal parameter), the next edge loads 8'h01 instead of shifting.
- out changes only on a clk edge or on reset assertion. There is no combinational path from rstn deassertion to out.
- No enable and no load: the generator runs continuously.

Test Plan:
- Reset value: hold rstn=1 for 3 clk edges -> out=8'h01 on every edge. Assert rstn asynchronously between edges -> out goes to 8'h01 within the same delta, before the next edge.
- First steps: release rstn, then 8 edges -> out = 02, 04, 08, 11, 23, 47, 8E, 1C in order.
- Full period:
  - Run 255 edges from 8'h01 -> all 255 nonzero values appear exactly once, 8'h00 is never seen, and edge 255 returns 8'h01.
- Mid-run reset: after 20 steps assert rstn for half a clock period -> out=8'h01 immediately. After release, the sequence restarts at 02.
- Lock-up recovery: force internal state to 8'h00 and release the force -> next edge out=8'h01, then 02.
- Parameter override: SEED=8'h00 -> reset value 8'h01. SEED=8'hA5 -> reset value A5, and the first step gives 4A (fb = 1^1^0^0 = 0).

Source files
------------

// File: rtl/lfsr_8b_gen.sv
// lfsr_8b_gen: free-running 8-bit maximal-length Fibonacci LFSR pattern source.
//   clk  - rising-edge clock
//   rstn - asynchronous reset, asserted high; loads SEED (00 mapped to 01)
//   out  - current registered LFSR state
module lfsr_8b_gen #(
   parameter logic [7:0] SEED = 8'h01,
   parameter logic [7:0] TAPS = 8'hB8
) (
   input  logic       clk,
   input  logic       rstn,
   output logic [7:0] out
);
   localparam logic [7:0] seed_ok = (SEED == 8'h00) ? 8'h01 : SEED;
   logic [7:0] state;
   logic [7:0] nxt;
   // all-zero state would lock the shifter; reseed it to 01 instead
   always_comb nxt = (state == 8'h00) ? 8'h01 : {state[6:0], ^(state & TAPS)};
   always_ff @(posedge clk or posedge rstn)
      if (rstn) state <= seed_ok;
      else state <= nxt;
   assign out = state;
endmodule

// File: tb/tb_lfsr_8b_gen.sv
// tb_lfsr_8b_gen: directed self-checking bench for lfsr_8b_gen.
`timescale 1ns/1ps
module tb_lfsr_8b_gen;
   logic       clk;
   logic       rstn;
   logic [7:0] out;
   logic [7:0] out_zero;
   logic [7:0] out_a5;
   int checks = 0;
   int failures = 0;
   bit seen [256];
   logic [7:0] first_seq [8] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};

   lfsr_8b_gen dut (.clk(clk), .rstn(rstn), .out(out));
   lfsr_8b_gen #(.SEED(8'h00)) u_zero (.clk(clk), .rstn(rstn), .out(out_zero));
   lfsr_8b_gen #(.SEED(8'hA5)) u_a5 (.clk(clk), .rstn(rstn), .out(out_a5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_hold", out, 8'h01);
         chk("reset_seed_zero", out_zero, 8'h01);
         chk("reset_seed_a5", out_a5, 8'hA5);
      end
      rstn = 1'b0;
      #1;
      chk("release_holds_seed", out, 8'h01);
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("first_step_%0d", i + 1), out, first_seq[i]);
         if (i == 0) chk("a5_first_step", out_a5, 8'h4A);
      end
      for (int i = 0; i < 12; i++) step();
      chk("step_20_nonzero_seed", {7'd0, out != 8'h01}, 8'h01);
      #2;
      rstn = 1'b1;
      #1;
      chk("async_reset_midrun", out, 8'h01);
      chk("async_reset_a5", out_a5, 8'hA5);
      #4;
      rstn = 1'b0;
      #0;
      chk("midrun_release_holds", out, 8'h01);
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      for (int i = 1; i <= 255; i++) begin
         step();
         if (i == 1) chk("restart_after_reset", out, 8'h02);
         if (i < 255) begin
            checks++;
            assert (out !== 8'h00 && out !== 8'h01 && !seen[out]) else begin
               failures++;
               $error("FAIL period_unique step %0d: observed=%h expected=unseen nonzero non-seed", i, out);
            end
            seen[out] = 1'b1;
         end
      end
      chk("period_255_returns_seed", out, 8'h01);
      step();
      chk("period_wraps_to_02", out, 8'h02);
      force dut.state = 8'h00;
      #1;
      release dut.state;
      #1;
      chk("lockup_forced_zero", out, 8'h00);
      step();
      chk("lockup_recover_01", out, 8'h01);
      step();
      chk("lockup_recover_02", out, 8'h02);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
